// File: rtl/ps2_scan_rx.sv
// PS/2 scancode receiver: glitch filter, 11-bit frame FSM, E0/E1/F0 prefix decoder, event buffer.
// Build option: define PS2_RX_FIFO_EN for a 4-entry event FIFO; otherwise a single holding register.
module ps2_scan_rx #(
    parameter logic [15:0] TIMEOUT = 16'd2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    output logic       valid,
    input  logic       ready,
    output logic [7:0] code,
    output logic       ext,
    output logic       released,
    output logic       frame_err,
    output logic       overflow
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Clock glitch filter and data sampling
    logic [7:0] filt_reg;
    logic [7:0] filt_next;
    logic       clean_reg;
    logic       data_reg;
    logic       fall;

    assign filt_next = {filt_reg[6:0], ps2[0]};
    assign fall      = ce && clean_reg && (filt_next == 8'h00);

    always_ff @(posedge clock) begin
        if (reset) begin
            filt_reg  <= 8'hFF;
            clean_reg <= 1'b1;
            data_reg  <= 1'b1;
        end else if (ce) begin
            filt_reg <= filt_next;
            data_reg <= ps2[1];
            if (filt_next == 8'hFF)
                clean_reg <= 1'b1;
            else if (filt_next == 8'h00)
                clean_reg <= 1'b0;
        end
    end

    // Frame FSM
    state_t      state_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic        parity_reg;
    logic [15:0] tmo_reg;
    logic        byte_stb_reg;
    logic [7:0]  byte_reg;
    logic        frame_err_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            parity_reg    <= 1'b0;
            tmo_reg       <= '0;
            byte_stb_reg  <= 1'b0;
            byte_reg      <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            byte_stb_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            if (state_reg == IDLE) begin
                tmo_reg <= '0;
                if (fall && !data_reg) begin
                    state_reg   <= DATA;
                    bit_cnt_reg <= '0;
                end
            end else if (fall) begin
                tmo_reg <= '0;
                case (state_reg)
                    DATA: begin
                        shift_reg   <= {data_reg, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7)
                            state_reg <= PARITY;
                    end
                    PARITY: begin
                        parity_reg <= data_reg;
                        state_reg  <= STOP;
                    end
                    default: begin
                        // Odd parity over data+parity and a high stop bit make a good frame
                        if (data_reg && (^{shift_reg, parity_reg})) begin
                            byte_stb_reg <= 1'b1;
                            byte_reg     <= shift_reg;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                endcase
            end else if (ce) begin
                if (tmo_reg + 16'd1 >= TIMEOUT) begin
                    state_reg     <= IDLE;
                    frame_err_reg <= 1'b1;
                    tmo_reg       <= '0;
                end else begin
                    tmo_reg <= tmo_reg + 16'd1;
                end
            end
        end
    end

    // Prefix decoder: E0/E1 mark extended, F0 marks release, 00/FF cancel
    logic       ext_pend_reg;
    logic       rel_pend_reg;
    logic       evt_stb_reg;
    logic [9:0] evt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            ext_pend_reg <= 1'b0;
            rel_pend_reg <= 1'b0;
            evt_stb_reg  <= 1'b0;
            evt_reg      <= '0;
        end else begin
            evt_stb_reg <= 1'b0;
            if (byte_stb_reg) begin
                case (byte_reg)
                    8'hE0, 8'hE1: ext_pend_reg <= 1'b1;
                    8'hF0:        rel_pend_reg <= 1'b1;
                    8'h00, 8'hFF: begin
                        ext_pend_reg <= 1'b0;
                        rel_pend_reg <= 1'b0;
                    end
                    default: begin
                        evt_stb_reg  <= 1'b1;
                        evt_reg      <= {ext_pend_reg, rel_pend_reg, byte_reg};
                        ext_pend_reg <= 1'b0;
                        rel_pend_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Event buffer; a pop on the same clock frees room for a push into a full buffer
    logic       push;
    logic       pop;
    logic       full;
    logic       accept;
    logic [9:0] head;
    logic       ovf_reg;

    assign push   = evt_stb_reg;
    assign pop    = valid && ready;
    assign accept = push && (!full || pop);

`ifdef PS2_RX_FIFO_EN
    logic [9:0] mem [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;

    assign full  = (count_reg == 3'd4);
    assign valid = (count_reg != 3'd0);
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clock) begin
        if (accept)
            mem[wr_ptr_reg] <= evt_reg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (accept)
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({accept, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end
`else
    logic [9:0] head_reg;
    logic       full_reg;

    assign full  = full_reg;
    assign valid = full_reg;
    assign head  = head_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg <= '0;
            full_reg <= 1'b0;
        end else begin
            if (accept) begin
                head_reg <= evt_reg;
                full_reg <= 1'b1;
            end else if (pop) begin
                full_reg <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset)
            ovf_reg <= 1'b0;
        else
            ovf_reg <= push && full && !pop;
    end

    // Head fields read as zero while the buffer is empty
    assign code      = valid ? head[7:0] : 8'h00;
    assign ext       = valid && head[9];
    assign released  = valid && head[8];
    assign frame_err = frame_err_reg;
    assign overflow  = ovf_reg;

endmodule

// File: doc/ps2_scan_rx.md
PS2_SCAN_RX -- requirements
Module: ps2_scan_rx

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd2000, ce ticks allowed between falling PS/2 clock edges inside a frame.
REQ-002 SHALL have port clock  input  1  system clock; the block's only clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ce  input  1  sampling enable; all PS/2 sampling, filtering and timeout counting advance only on clocks where ce=1.
REQ-005 SHALL have port ps2  input  2  raw PS/2 lines: ps2[0] clock, ps2[1] data.
REQ-006 SHALL have port valid  output  1  event available at the output.
REQ-007 SHALL have port ready  input  1  consumer accepts the event.
REQ-008 SHALL have port code  output  8  scancode of the head event.
REQ-009 SHALL have port ext  output  1  head event was preceded by an E0 or E1 prefix.
REQ-010 SHALL have port released  output  1  head event was preceded by an F0 prefix.
REQ-011 SHALL have port frame_err  output  1  one-clock pulse on a discarded frame.
REQ-012 SHALL have port overflow  output  1  one-clock pulse when an event is dropped.

Function
REQ-013 Filter: an 8-bit shift register SHALL sample ps2[0] each ce; the clean clock goes 1 when all bits are 1, goes 0 when all bits are 0, and holds otherwise.
REQ-014 Edge: a falling edge SHALL be the ce on which the clean clock changes 1->0; ps2[1], registered on the previous ce, is the bit sampled.
REQ-015 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on an edge with bit 0 -> DATA, count=0; with bit 1 -> stay in IDLE, no error.
REQ-017 DATA: shift bits in LSB first; after the 8th bit -> PARITY.
REQ-018 PARITY: capture the bit; -> STOP.
REQ-019 STOP: if the stop bit is 1 and the 8 data bits plus parity contain an odd number of 1s, deliver the byte to the decoder; otherwise pulse frame_err. In both cases -> IDLE.
REQ-020 Timeout: a 16-bit counter SHALL clear on every edge and increment on every ce outside IDLE; when it reaches TIMEOUT, go to IDLE, pulse frame_err and discard the partial byte.
REQ-021 Decoder: E0 and E1 set the pending ext flag; F0 sets the pending rel flag; 00 and FF clear both flags and emit nothing; any other byte emits an event {ext, rel, code} and clears both flags.
REQ-022 Latency: valid SHALL rise exactly 2 clocks after the clock on which the stop-bit edge was accepted, when the buffer was empty.
REQ-023 Handshake: an event is consumed on a clock with valid=1 and ready=1; code, ext and released stay stable while valid=1 and ready=0.
REQ-024 Full buffer plus new event with no pop SHALL drop the new event and pulse overflow; the stored events are unchanged.
REQ-025 Full buffer plus new event plus pop on the same clock SHALL accept the new event with no overflow.
REQ-026 A consecutive byte whose stop bit lands on the same clock as a pop SHALL not be lost.

Reset
REQ-027 Reset SHALL force the filter to 8'hFF, clean clock to 1, FSM to IDLE, counter to 0, both flags to 0 and the buffer to empty.
REQ-028 While reset=1 and on the first clock after it, outputs SHALL be valid=0, code=0, ext=0, released=0, frame_err=0, overflow=0.
REQ-029 Reset mid-frame SHALL discard the partial byte without pulsing frame_err.

Configuration
REQ-030 With PS2_RX_FIFO_EN defined, the buffer SHALL be a 4-entry FIFO of 10-bit events with 2-bit wrapping pointers and full/empty derived from an occupancy count of 0..4.
REQ-031 Without PS2_RX_FIFO_EN, the buffer SHALL be a single register (depth 1), with REQ-022..REQ-026 applying to depth 1.

Verification
REQ-032 Frame 0x1C with correct parity and stop, ready=1 -> valid for 1 clock with code=1C, ext=0, released=0.
REQ-033 Byte sequence E0,F0,75 -> one event with code=75, ext=1, released=1; no event for the prefixes.
REQ-034 Frame 0x16 with bad parity -> frame_err pulse, no event; next good 0x16 -> event code=16.
REQ-035 Clock stops after 4 data bits for more than TIMEOUT ce ticks -> frame_err pulse; next full frame 0x29 -> event code=29.
REQ-036 ready=0 and 6 events sent -> FIFO build holds 4 and pulses overflow twice, non-FIFO build holds 1 and pulses overflow 5 times; raising ready drains the first events in arrival order.
REQ-037 1 ce glitch (low) on ps2[0] while idle -> no edge and no state change.
